// File: rtl/timestamp_latency_meas_if.sv
// ----------------------------------------------------------------------------
// timestamp_latency_meas_if
//   The AXI4-Stream beat signals observed by the latency monitor.
//   master : whoever drives the stream (the padding stage or a bench)
//   slave  : passive observer; every signal is an input, including tready
// Signals:
//   s_axis_tdata  [C_S_AXIS_TDATA_WIDTH] stream data, timestamp in [63:0]
//   s_axis_tvalid                        beat valid
//   s_axis_tready                        beat ready (observed only)
//   s_axis_tlast                         last beat of packet
// ----------------------------------------------------------------------------
interface timestamp_latency_meas_if #(
    parameter int C_S_AXIS_TDATA_WIDTH = 256
) ();
    logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
    logic                            s_axis_tvalid;
    logic                            s_axis_tready;
    logic                            s_axis_tlast;

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tready,
        output s_axis_tlast
    );

    modport slave (
        input s_axis_tdata,
        input s_axis_tvalid,
        input s_axis_tready,
        input s_axis_tlast
    );
endinterface

// File: rtl/timestamp_latency_meas.sv
// ----------------------------------------------------------------------------
// timestamp_latency_meas
//   Passive RX monitor. Captures the 64-bit timestamp found at a programmed
//   word position of each packet, computes latency = ref_counter - timestamp
//   and keeps min/max/saturating-sum/count statistics. Never drives the bus.
// Ports:
//   axi_aclk, axi_resetn   clock, asynchronous active-low reset
//   ref_counter[63:0]      local time reference
//   ts_valid, ts_position  per-packet enable and word index (latched on beat 0)
//   clear_stats            one-cycle synchronous clear of statistics/counters
//   s_axis                 observed stream (interface, slave modport)
//   latency, latency_valid most recent accepted sample and its pulse
//   latency_min/max/sum    statistics over accepted samples
//   sample_cnt, short_pkt_cnt, neg_lat_cnt   saturating event counters
// ----------------------------------------------------------------------------
module timestamp_latency_meas #(
    parameter int C_S_AXIS_TDATA_WIDTH = 256,
    parameter int TS_POSITION_WIDTH    = 8
) (
    input  logic                         axi_aclk,
    input  logic                         axi_resetn,
    input  logic [63:0]                  ref_counter,
    input  logic                         ts_valid,
    input  logic [TS_POSITION_WIDTH-1:0] ts_position,
    input  logic                         clear_stats,
    timestamp_latency_meas_if.slave      s_axis,
    output logic [63:0]                  latency,
    output logic                         latency_valid,
    output logic [63:0]                  latency_min,
    output logic [63:0]                  latency_max,
    output logic [63:0]                  latency_sum,
    output logic [31:0]                  sample_cnt,
    output logic [31:0]                  short_pkt_cnt,
    output logic [31:0]                  neg_lat_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE, ST_SKIP} state_t;

    function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] a);
        return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
    endfunction

    logic [C_S_AXIS_TDATA_WIDTH-1:0] tdata;
    logic                            unused_tdata;
    logic                            beat;
    logic signed [63:0]              diff_s;
    logic                            capture;
    logic                            short_hit;
    logic                            pos_match;

    state_t                       state_q, state_d;
    logic [7:0]                   wc_q, wc_d;
    logic [TS_POSITION_WIDTH-1:0] pos_q, pos_d;
    logic [63:0]                  latency_q, latency_d;
    logic                         latency_valid_q, latency_valid_d;
    logic [63:0]                  min_q, min_d;
    logic [63:0]                  max_q, max_d;
    logic [63:0]                  sum_q, sum_d;
    logic [31:0]                  sample_cnt_q, sample_cnt_d;
    logic [31:0]                  short_cnt_q, short_cnt_d;
    logic [31:0]                  neg_cnt_q, neg_cnt_d;

    assign tdata        = s_axis.s_axis_tdata;
    // Only the low 64 bits matter; the reduction keeps the full bus referenced.
    assign unused_tdata = ^tdata;
    assign beat         = s_axis.s_axis_tvalid & s_axis.s_axis_tready;
    // Modulo-2^64 difference; a set sign bit means the timestamp is in the future.
    assign diff_s       = signed'(ref_counter - tdata[63:0]);
    assign pos_match    = (32'(wc_q) == 32'(pos_q));

    // Packet FSM and word counter
    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        pos_d     = pos_q;
        capture   = 1'b0;
        short_hit = 1'b0;
        if (beat) begin
            wc_d = s_axis.s_axis_tlast ? 8'd0 : ((wc_q == 8'hFF) ? wc_q : wc_q + 8'd1);
            unique case (state_q)
                ST_IDLE: begin
                    pos_d = ts_position;
                    if (ts_valid && (ts_position == '0)) capture = 1'b1;
                    if (s_axis.s_axis_tlast)        state_d = ST_IDLE;
                    else if (!ts_valid)             state_d = ST_SKIP;
                    else if (ts_position == '0)     state_d = ST_DONE;
                    else                            state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (pos_match) begin
                        capture = 1'b1;
                        state_d = s_axis.s_axis_tlast ? ST_IDLE : ST_DONE;
                    end else if (s_axis.s_axis_tlast) begin
                        short_hit = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    if (s_axis.s_axis_tlast) state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sample registration and statistics
    always_comb begin
        latency_d       = latency_q;
        latency_valid_d = 1'b0;
        min_d           = min_q;
        max_d           = max_q;
        sum_d           = sum_q;
        sample_cnt_d    = sample_cnt_q;
        short_cnt_d     = short_cnt_q;
        neg_cnt_d       = neg_cnt_q;
        if (capture) begin
            if (diff_s < 0) begin
                neg_cnt_d = sat_inc32(neg_cnt_q);
            end else begin
                latency_d       = diff_s;
                latency_valid_d = 1'b1;
            end
        end
        if (short_hit) short_cnt_d = sat_inc32(short_cnt_q);
        // Statistics trail the latency register by one cycle.
        if (latency_valid_q) begin
            if (latency_q < min_q) min_d = latency_q;
            if (latency_q > max_q) max_d = latency_q;
            sum_d        = sat_add64(sum_q, latency_q);
            sample_cnt_d = sat_inc32(sample_cnt_q);
        end
        // Clear has priority over any update landing in the same cycle.
        if (clear_stats) begin
            min_d        = 64'hFFFF_FFFF_FFFF_FFFF;
            max_d        = '0;
            sum_d        = '0;
            sample_cnt_d = '0;
            short_cnt_d  = '0;
            neg_cnt_d    = '0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q         <= ST_IDLE;
            wc_q            <= '0;
            pos_q           <= '0;
            latency_q       <= '0;
            latency_valid_q <= 1'b0;
            min_q           <= 64'hFFFF_FFFF_FFFF_FFFF;
            max_q           <= '0;
            sum_q           <= '0;
            sample_cnt_q    <= '0;
            short_cnt_q     <= '0;
            neg_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            wc_q            <= wc_d;
            pos_q           <= pos_d;
            latency_q       <= latency_d;
            latency_valid_q <= latency_valid_d;
            min_q           <= min_d;
            max_q           <= max_d;
            sum_q           <= sum_d;
            sample_cnt_q    <= sample_cnt_d;
            short_cnt_q     <= short_cnt_d;
            neg_cnt_q       <= neg_cnt_d;
        end
    end

    assign latency       = latency_q;
    assign latency_valid = latency_valid_q;
    assign latency_min   = min_q;
    assign latency_max   = max_q;
    assign latency_sum   = sum_q;
    assign sample_cnt    = sample_cnt_q;
    assign short_pkt_cnt = short_cnt_q;
    assign neg_lat_cnt   = neg_cnt_q;

endmodule

// File: tb/tb_timestamp_latency_meas.sv
// ----------------------------------------------------------------------------
// tb_timestamp_latency_meas
//   Directed bench for timestamp_latency_meas. Expected latencies are queued
//   when a capturing beat is driven and popped when latency_valid appears.
// ----------------------------------------------------------------------------
module tb_timestamp_latency_meas;

    localparam int DW = 256;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BIG  = 64'h7FFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        axi_resetn;
    logic [63:0] ref_counter;
    logic        ts_valid;
    logic [7:0]  ts_position;
    logic        clear_stats;
    logic [63:0] latency, latency_min, latency_max, latency_sum;
    logic        latency_valid;
    logic [31:0] sample_cnt, short_pkt_cnt, neg_lat_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] sb[$];

    timestamp_latency_meas_if #(.C_S_AXIS_TDATA_WIDTH(DW)) s_if ();

    timestamp_latency_meas #(
        .C_S_AXIS_TDATA_WIDTH(DW),
        .TS_POSITION_WIDTH   (8)
    ) dut (
        .axi_aclk     (clk),
        .axi_resetn   (axi_resetn),
        .ref_counter  (ref_counter),
        .ts_valid     (ts_valid),
        .ts_position  (ts_position),
        .clear_stats  (clear_stats),
        .s_axis       (s_if),
        .latency      (latency),
        .latency_valid(latency_valid),
        .latency_min  (latency_min),
        .latency_max  (latency_max),
        .latency_sum  (latency_sum),
        .sample_cnt   (sample_cnt),
        .short_pkt_cnt(short_pkt_cnt),
        .neg_lat_cnt  (neg_lat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every latency_valid pulse must match the oldest queued sample.
    always @(negedge clk) begin
        if (axi_resetn === 1'b1 && latency_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL unexpected_valid observed=%0h expected=none", latency);
            end else begin
                chk("sb_latency", latency, sb.pop_front());
            end
        end
    end

    // One clock of stream activity; called and returning on a falling edge.
    task automatic drive(input logic [63:0] ts, input logic [63:0] refc,
                         input logic last, input logic rdy, input logic cap);
        s_if.s_axis_tdata        = '1;
        s_if.s_axis_tdata[63:0]  = ts;
        s_if.s_axis_tvalid       = 1'b1;
        s_if.s_axis_tready       = rdy;
        s_if.s_axis_tlast        = last;
        ref_counter              = refc;
        if (cap) sb.push_back(refc - ts);
        @(posedge clk);
        @(negedge clk);
        s_if.s_axis_tvalid = 1'b0;
        s_if.s_axis_tready = 1'b0;
        s_if.s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        idle(1);
        clear_stats = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_lat"},   latency, 64'd0);
        chk({tag, "_vld"},   {63'd0, latency_valid}, 64'd0);
        chk({tag, "_min"},   latency_min, ONES);
        chk({tag, "_max"},   latency_max, 64'd0);
        chk({tag, "_sum"},   latency_sum, 64'd0);
        chk({tag, "_cnt"},   {32'd0, sample_cnt}, 64'd0);
        chk({tag, "_short"}, {32'd0, short_pkt_cnt}, 64'd0);
        chk({tag, "_neg"},   {32'd0, neg_lat_cnt}, 64'd0);
    endtask

    task automatic check_stats(input string tag, input logic [63:0] mn, input logic [63:0] mx,
                               input logic [63:0] sm, input logic [31:0] cnt);
        chk({tag, "_min"}, latency_min, mn);
        chk({tag, "_max"}, latency_max, mx);
        chk({tag, "_sum"}, latency_sum, sm);
        chk({tag, "_cnt"}, {32'd0, sample_cnt}, {32'd0, cnt});
    endtask

    initial begin
        axi_resetn          = 1'b0;
        ref_counter         = '0;
        ts_valid            = 1'b0;
        ts_position         = '0;
        clear_stats         = 1'b0;
        s_if.s_axis_tdata   = '0;
        s_if.s_axis_tvalid  = 1'b0;
        s_if.s_axis_tready  = 1'b0;
        s_if.s_axis_tlast   = 1'b0;
        idle(2);
        check_reset("reset");
        axi_resetn = 1'b1;
        idle(1);

        // Position-2 capture in a 4-beat packet
        ts_valid = 1'b1; ts_position = 8'd2;
        drive(64'd5, 64'd0, 1'b0, 1'b1, 1'b0);
        drive(64'd6, 64'd0, 1'b0, 1'b1, 1'b0);
        drive(64'd1000, 64'd1250, 1'b0, 1'b1, 1'b1);
        chk("pos2_vld", {63'd0, latency_valid}, 64'd1);
        chk("pos2_lat", latency, 64'd250);
        chk("pos2_cnt_early", {32'd0, sample_cnt}, 64'd0);
        drive(64'd7, 64'd0, 1'b1, 1'b1, 1'b0);
        check_stats("pos2", 64'd250, 64'd250, 64'd250, 32'd1);

        // Accumulation over back-to-back single-beat packets
        pulse_clear();
        check_stats("clr1", ONES, 64'd0, 64'd0, 32'd0);
        ts_position = 8'd0;
        drive(64'd0, 64'd300, 1'b1, 1'b1, 1'b1);
        drive(64'd0, 64'd100, 1'b1, 1'b1, 1'b1);
        drive(64'd0, 64'd200, 1'b1, 1'b1, 1'b1);
        idle(1);
        check_stats("accum", 64'd100, 64'd300, 64'd600, 32'd3);

        // Clear landing on the same cycle as the third update
        pulse_clear();
        drive(64'd0, 64'd300, 1'b1, 1'b1, 1'b1);
        drive(64'd0, 64'd100, 1'b1, 1'b1, 1'b1);
        drive(64'd0, 64'd200, 1'b1, 1'b1, 1'b1);
        pulse_clear();
        check_stats("clr_win", ONES, 64'd0, 64'd0, 32'd0);

        // Short packet, then a normal capture
        ts_position = 8'd5;
        drive(64'd1, 64'd2, 1'b0, 1'b1, 1'b0);
        drive(64'd1, 64'd2, 1'b0, 1'b1, 1'b0);
        drive(64'd1, 64'd2, 1'b1, 1'b1, 1'b0);
        chk("short_cnt", {32'd0, short_pkt_cnt}, 64'd1);
        chk("short_novld", {63'd0, latency_valid}, 64'd0);
        ts_position = 8'd1;
        drive(64'd9, 64'd9, 1'b0, 1'b1, 1'b0);
        drive(64'd3, 64'd10, 1'b1, 1'b1, 1'b1);
        idle(1);
        check_stats("after_short", 64'd7, 64'd7, 64'd7, 32'd1);

        // Negative latency
        ts_position = 8'd0;
        drive(64'd20, 64'd10, 1'b1, 1'b1, 1'b0);
        chk("neg_cnt", {32'd0, neg_lat_cnt}, 64'd1);
        chk("neg_novld", {63'd0, latency_valid}, 64'd0);
        idle(1);
        check_stats("after_neg", 64'd7, 64'd7, 64'd7, 32'd1);

        // Enable dropped after first beat, tready toggling
        ts_valid = 1'b1; ts_position = 8'd2;
        drive(64'd11, 64'd0, 1'b0, 1'b1, 1'b0);
        ts_valid = 1'b0; ts_position = 8'd0;
        drive(64'd12, 64'd0, 1'b0, 1'b0, 1'b0);
        drive(64'd12, 64'd0, 1'b0, 1'b1, 1'b0);
        drive(64'd9999, 64'd600, 1'b0, 1'b0, 1'b0);
        drive(64'd500, 64'd600, 1'b0, 1'b1, 1'b1);
        chk("bp_vld", {63'd0, latency_valid}, 64'd1);
        drive(64'd13, 64'd0, 1'b1, 1'b1, 1'b0);
        // Disabled packet: no sample expected
        drive(64'd0, 64'd50, 1'b0, 1'b1, 1'b0);
        drive(64'd0, 64'd50, 1'b1, 1'b1, 1'b0);
        idle(2);
        check_stats("bp", 64'd7, 64'd100, 64'd107, 32'd2);

        // Saturating sum
        pulse_clear();
        ts_valid = 1'b1; ts_position = 8'd0;
        drive(64'd0, BIG, 1'b1, 1'b1, 1'b1);
        drive(64'd0, BIG, 1'b1, 1'b1, 1'b1);
        drive(64'd0, BIG, 1'b1, 1'b1, 1'b1);
        chk("sum_two", latency_sum, ONES - 64'd1);
        idle(1);
        check_stats("sat", BIG, BIG, ONES, 32'd3);

        // Asynchronous reset in the middle of a packet
        ts_position = 8'd3;
        drive(64'd1, 64'd1, 1'b0, 1'b1, 1'b0);
        drive(64'd1, 64'd1, 1'b0, 1'b1, 1'b0);
        #2;
        axi_resetn = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        axi_resetn = 1'b1;
        // Remainder of the packet now starts a new one
        ts_position = 8'd0;
        drive(64'd8, 64'd50, 1'b0, 1'b1, 1'b1);
        chk("rst_resume_lat", latency, 64'd42);
        drive(64'd1, 64'd1, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/timestamp_latency_meas.md
# timestamp_latency_meas

Passive receive-side monitor that sits directly downstream of the timestamp padding stage on the RX path. It watches the AXI4-Stream beats leaving the padding stage and captures the 64-bit timestamp carried at a programmed word position of each packet. It computes one-way latency against the local reference counter and maintains min/max/sum/count statistics for the register block. It never drives tready and never alters data.

## Interface
Parameters:
- C_S_AXIS_TDATA_WIDTH, 256, monitored stream data width (≥64)
- TS_POSITION_WIDTH, 8, width of the word-position field

Ports:
- axi_aclk  in  1  single clock
- axi_resetn  in  1  asynchronous, active-low reset
- ref_counter  in  64  free-running local time reference, same domain as the padding stage
- ts_valid  in  1  measurement enable
- ts_position  in  TS_POSITION_WIDTH  word index (0 = first beat) holding the timestamp
- clear_stats  in  1  synchronous one-cycle clear of all statistics
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  monitored data; timestamp in bits [63:0]
- s_axis_tvalid  in  1  monitored valid
- s_axis_tready  in  1  monitored ready (observed only)
- s_axis_tlast  in  1  monitored last
- latency  out  64  most recent valid latency
- latency_valid  out  1  one-cycle pulse per accepted sample
- latency_min  out  64  minimum accepted latency
- latency_max  out  64  maximum accepted latency
- latency_sum  out  64  saturating sum of accepted latencies
- sample_cnt  out  32  saturating count of accepted samples
- short_pkt_cnt  out  32  saturating count of enabled packets ending before ts_position
- neg_lat_cnt  out  32  saturating count of samples rejected as negative

## Operation
- Beat = s_axis_tvalid & s_axis_tready. All state advances only on beats, except clear_stats.
- Word counter: 8 bits, cleared on a tlast beat, incremented on other beats, saturates at 255 (no wrap).
- Packet FSM:
  - IDLE: on the first beat, latch ts_valid and ts_position for the whole packet. Mid-packet changes are ignored.
    - Enabled and position 0 → capture on this beat.
    - Enabled and position nonzero → ARMED.
    - Disabled → SKIP.
    - A single-beat packet returns to IDLE.
  - ARMED: the beat with word counter == latched position is captured, then DONE. A tlast beat before that word increments short_pkt_cnt, then IDLE.
  - DONE / SKIP: wait for the tlast beat, then IDLE.
- Capture: diff = ref_counter − s_axis_tdata[63:0], modulo 2^64, registered.
  - diff[63] == 1: treated as negative. Increments neg_lat_cnt, no latency_valid, stats unchanged.
  - Otherwise: latency ← diff and latency_valid pulses.
- Stats update on each accepted sample:
  - min ← min(min, latency); max ← max(max, latency).
  - sum ← sum + latency, saturating at 2^64−1.
  - sample_cnt += 1, saturating at 2^32−1.
- clear_stats resets min, max, sum and all counters to their reset values. If it coincides with an update, the clear wins and that sample is dropped from the stats. latency itself is not cleared.
- Reset values:
  - latency = 0, latency_valid = 0
  - latency_min = 64'hFFFF_FFFF_FFFF_FFFF, latency_max = 0, latency_sum = 0
  - all counters 0; FSM in IDLE; word counter 0.
- Reset asserted mid-packet: the remainder of that packet is treated as a new packet starting at its next beat. This is accepted behaviour.

## Timing
- Capture beat at cycle N → latency and latency_valid registered at N+1.
- latency_min, latency_max, latency_sum and sample_cnt reflect the sample at N+2.
- short_pkt_cnt and neg_lat_cnt update at N+1 after the causing beat.
- Back-to-back captures on consecutive cycles (single-beat packets) are fully supported: one sample per cycle with no loss.
- Idle cycles (tvalid without tready, or no tvalid) hold all state.

## Test plan
- Pos-2 capture: ts_valid=1, ts_position=2, 4-beat packet, word-2 tdata[63:0]=1000, ref_counter=1250 at the capture beat → latency=250, latency_valid pulse at N+1, then min=max=sum=250 and sample_cnt=1.
- Stats accumulation: three packets with latencies 300, 100, 200 → min=100, max=300, sum=600, sample_cnt=3. Assert clear_stats on the cycle the third sample updates → min=all-ones, max=0, sum=0, sample_cnt=0.
- Short packet: ts_position=5, 3-beat packet → short_pkt_cnt=1, no latency_valid. The next packet is captured normally.
- Negative latency: ref_counter=10, captured ts=20 → neg_lat_cnt=1, no latency_valid, stats unchanged.
- Enable/backpressure: deassert ts_valid after the first beat with tready toggling 1-0-1 → capture still occurs on the correct word. A packet whose first beat has ts_valid=0 yields no sample.
- Saturation and reset: preload sum near 2^64−1 via repeated large latencies → sum sticks at 2^64−1. Assert axi_resetn=0 asynchronously mid-packet → all outputs return to their reset values immediately.
